uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//   UART transmit serializer for the memory-mapped console. Sits between
//   data_memory's UART TX outputs (byte + write strobe) and the top-level
//   serial pin. Buffers bytes in a small FIFO so the core is not stalled
//   by baud timing, then emits 8N1 frames, LSB first, on uart_txd.
// PARAMETERS
//   CLK_FREQ    50_000_000  system clock frequency, Hz
//   BAUD_RATE   115_200     line rate, bit/s
//   FIFO_DEPTH  4           byte buffer entries; power of two, >=2
//   CLKS_PER_BIT (localparam) = CLK_FREQ/BAUD_RATE (integer division);
//               elaboration must fail ($error) if the result is <2
// PORTS
//   clk          in   1  system clock, all state on rising edge
//   rst          in   1  asynchronous, active-low reset
//   tx_data      in   8  byte to send (from data_memory uart_tx_out)
//   tx_valid     in   1  write strobe; each high cycle = one enqueue
//   uart_txd     out  1  serial line, idle high, registered
//   tx_busy      out  1  FIFO non-empty or frame in progress
//   tx_full      out  1  FIFO holds FIFO_DEPTH bytes
//   tx_overflow  out  1  sticky: a byte was dropped; cleared only by rst
// BEHAVIOUR
//   Reset (rst=0, async): uart_txd=1, tx_busy=0, tx_full=0,
//     tx_overflow=0, FIFO empty, FSM=IDLE, counters=0. Asserting rst
//     mid-frame aborts the frame; uart_txd goes high at once.
//   Enqueue: on edge with tx_valid=1 and FIFO not full, tx_data is
//     written. If full at that edge, the byte is dropped and
//     tx_overflow<=1, even if the FSM pops in the same cycle.
//   Simultaneous push+pop on non-full FIFO: both happen, count unchanged.
//   Push into empty FIFO: FSM sees non-empty on the following edge
//     (no same-cycle bypass).
//   FSM states: IDLE, START, DATA, STOP.
//     IDLE : txd=1. If FIFO non-empty: pop byte into shift reg,
//            baud_cnt<=0, ->START.
//     START: txd=0 for CLKS_PER_BIT cycles, ->DATA, bit_idx<=0.
//     DATA : txd=shift[0] for CLKS_PER_BIT cycles each, shift right;
//            after bit_idx==7 ->STOP.
//     STOP : txd=1 for CLKS_PER_BIT cycles. Then: if FIFO non-empty,
//            pop and ->START directly (no idle gap); else ->IDLE.
//   Latency: byte accepted at edge N into an empty idle block ->
//     uart_txd low from edge N+2 (N+1: FIFO non-empty, N+2: pop, START).
//   Frame: exactly 10*CLKS_PER_BIT cycles; every bit the same length.
//   baud_cnt counts 0..CLKS_PER_BIT-1; the bit ends at terminal count.
//   tx_busy = (state!=IDLE) | ~fifo_empty; combinational from registers.
//   FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally.
//   A count register (log2(FIFO_DEPTH)+1 bits) drives full/empty.
//   tx_data is sampled only on accepted edges; X when idle is harmless.
// STRUCTURE
//   uart_defs.vh: FSM state encodings (2-bit localparams), 8N1 frame
//     constants (DATA_BITS=8, STOP_BITS=1). Shared with a future uart_rx.
//   Sub-module uart_tx_fifo: sync FIFO (clk, rst, push, din, pop, dout,
//     full, empty). It provides no overflow logic; the parent owns
//     tx_overflow.
//   Top: FSM, baud counter, bit index, shift register, txd register.
// TESTING  (CLK_FREQ=1_000_000, BAUD_RATE=100_000 -> 10 clk/bit, DEPTH=4)
//   1 Single byte: write 0x55 -> txd 0 x10clk, bits 1,0,1,0,1,0,1,0
//     x10clk each, 1 x10clk; tx_busy falls after 100 clk; idle line=1.
//   2 Burst: 5 writes on consecutive clocks -> all 5 frames sent
//     back-to-back, no idle gap; tx_full high after 5th write;
//     overflow=0.
//   3 Overflow: 6 consecutive writes 0xA0..0xA5 -> 0xA5 dropped,
//     tx_overflow=1 and stays 1; bytes 0xA0..0xA4 appear in order.
//   4 Full + pop same cycle: fill FIFO, write during STOP->START pop edge
//     -> byte dropped, overflow=1.
//   5 Reset mid-frame: rst=0 during DATA bit 3 -> txd=1 asynchronously,
//     busy=0; after release, write 0x0F -> clean full frame.
//   6 Scoreboard: 200 random bytes with random gaps, never full ->
//     line decoder reconstructs identical sequence; each frame 100 clk.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// ============================================================================
//  Module   : uart_tx_pkg
//  Purpose  : Shared 8N1 frame constants and transmitter FSM state encoding.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_tx_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  function automatic int calc_clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage : uart_tx_pkg

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================================
//  Module   : uart_tx_fifo
//  Purpose  : Small synchronous FIFO buffering console bytes ahead of the
//             serializer. Overflow tracking belongs to the parent.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] c_depth = (AW + 1)'(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("uart_tx_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  assign full  = (r_count == c_depth);
  assign empty = (r_count == '0);
  assign dout  = r_mem[r_rd_ptr];

  // Pointers are exactly log2(DEPTH) wide, so wrap-around is free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

endmodule : uart_tx_fifo

`default_nettype wire

// File: rtl/uart_tx.sv
// ============================================================================
//  Module   : uart_tx
//  Purpose  : Buffered 8N1 UART transmitter for the memory-mapped console;
//             bytes are queued in a FIFO and serialized LSB first.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       uart_txd,
  output logic       tx_busy,
  output logic       tx_full,
  output logic       tx_overflow
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int CW = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
  localparam int IW = 3;

  localparam logic [CW-1:0] c_cnt_last  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] c_last_data = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] c_last_stop = IW'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_tx: CLK_FREQ/BAUD_RATE must be at least 2");
  end

  tx_state_t              r_state;
  tx_state_t              w_next_state;
  logic [CW-1:0]          r_baud_cnt;
  logic [IW-1:0]          r_bit_idx;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_txd;
  logic                   r_overflow;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_bit_done;
  logic [DATA_BITS-1:0]   w_fifo_dout;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;

  // A full FIFO rejects the write even if the FSM pops on the same edge.
  assign w_push     = tx_valid & ~w_fifo_full;
  assign w_bit_done = (r_baud_cnt == c_cnt_last);

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .din   (tx_data),
    .pop   (w_pop),
    .dout  (w_fifo_dout),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop        = 1'b1;
          w_next_state = ST_START;
        end
      end
      ST_START: begin
        if (w_bit_done) begin
          w_next_state = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_bit_done && (r_bit_idx == c_last_data)) begin
          w_next_state = ST_STOP;
        end
      end
      ST_STOP: begin
        // Chain straight into the next start bit when more data is queued.
        if (w_bit_done && (r_bit_idx == c_last_stop)) begin
          if (!w_fifo_empty) begin
            w_pop        = 1'b1;
            w_next_state = ST_START;
          end else begin
            w_next_state = ST_IDLE;
          end
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_txd      <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (tx_valid && w_fifo_full) begin
        r_overflow <= 1'b1;
      end

      // Line level follows the state of the previous cycle.
      case (r_state)
        ST_START: r_txd <= 1'b0;
        ST_DATA:  r_txd <= r_shift[0];
        default:  r_txd <= 1'b1;
      endcase

      if (w_pop) begin
        r_shift    <= w_fifo_dout;
        r_baud_cnt <= '0;
        r_bit_idx  <= '0;
      end else if (r_state != ST_IDLE) begin
        if (w_bit_done) begin
          r_baud_cnt <= '0;
          if (r_state == ST_DATA) begin
            r_shift <= {1'b0, r_shift[DATA_BITS-1:1]};
          end
          if (w_next_state != r_state) begin
            r_bit_idx <= '0;
          end else begin
            r_bit_idx <= r_bit_idx + IW'(1);
          end
        end else begin
          r_baud_cnt <= r_baud_cnt + CW'(1);
        end
      end
    end
  end

  assign uart_txd    = r_txd;
  assign tx_busy     = (r_state != ST_IDLE) | ~w_fifo_empty;
  assign tx_full     = w_fifo_full;
  assign tx_overflow = r_overflow;

endmodule : uart_tx

`default_nettype wire

// File: tb/tb_uart_tx.sv
// ============================================================================
//  Module   : tb_uart_tx
//  Purpose  : Self-checking bench for uart_tx against a frame-level model.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_tx;

  localparam int CLK_FREQ  = 1_000_000;
  localparam int BAUD_RATE = 100_000;
  localparam int DEPTH     = 4;
  localparam int CPB       = CLK_FREQ / BAUD_RATE;
  localparam int FRAME     = 10 * CPB;

  logic       clk      = 1'b0;
  logic       rst      = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_valid = 1'b0;
  logic       uart_txd;
  logic       tx_busy;
  logic       tx_full;
  logic       tx_overflow;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  uart_tx #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .uart_txd    (uart_txd),
    .tx_busy     (tx_busy),
    .tx_full     (tx_full),
    .tx_overflow (tx_overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Frame-level model: queue of waiting bytes plus the position inside the
  // frame currently on the wire; the line shows that position one clock late.
  logic [7:0] m_q[$];
  logic [7:0] exp_q[$];
  bit         m_active = 1'b0;
  int         m_p      = 0;
  logic [7:0] m_byte   = 8'h00;
  bit         m_txd    = 1'b1;
  bit         m_ovf    = 1'b0;
  int         frames_decoded = 0;

  function automatic bit frame_bit(input logic [7:0] b, input int p);
    int s;
    s = p / CPB;
    if (s == 0) return 1'b0;
    if (s <= 8) return b[s-1];
    return 1'b1;
  endfunction

  initial begin
    bit was_full;
    bit pop_now;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_q.delete();
        exp_q.delete();
        m_active = 1'b0;
        m_p      = 0;
        m_txd    = 1'b1;
        m_ovf    = 1'b0;
      end else begin
        m_txd    = m_active ? frame_bit(m_byte, m_p) : 1'b1;
        was_full = (m_q.size() == DEPTH);
        pop_now  = 1'b0;
        if (m_active) begin
          if (m_p == FRAME - 1) begin
            if (m_q.size() > 0) pop_now = 1'b1;
            else m_active = 1'b0;
          end else begin
            m_p++;
          end
        end else if (m_q.size() > 0) begin
          pop_now = 1'b1;
        end
        if (pop_now) begin
          m_byte   = m_q.pop_front();
          m_p      = 0;
          m_active = 1'b1;
        end
        if (tx_valid) begin
          if (was_full) m_ovf = 1'b1;
          else begin
            m_q.push_back(tx_data);
            exp_q.push_back(tx_data);
          end
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      check("txd",      uart_txd,    m_txd);
      check("busy",     tx_busy,     m_active || (m_q.size() > 0));
      check("full",     tx_full,     m_q.size() == DEPTH);
      check("overflow", tx_overflow, m_ovf);
    end
  end

  // Independent line decoder sampling mid-bit.
  initial begin
    bit         rxing;
    int         cnt;
    int         k;
    logic [7:0] sh;
    rxing = 1'b0;
    cnt   = 0;
    sh    = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst) begin
        rxing = 1'b0;
      end else if (!rxing) begin
        if (uart_txd === 1'b0) begin
          rxing = 1'b1;
          cnt   = 0;
        end
      end else begin
        cnt++;
        if ((cnt % CPB) == (CPB / 2)) begin
          k = cnt / CPB;
          if (k == 0) begin
            check("dec_start", uart_txd, 1'b0);
          end else if (k <= 8) begin
            sh[k-1] = uart_txd;
          end else begin
            check("dec_stop", uart_txd, 1'b1);
            check("dec_expected_avail", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) check("dec_byte", sh, exp_q.pop_front());
            frames_decoded++;
            rxing = 1'b0;
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Writes on consecutive clocks; returns just after the last accepting edge.
  task automatic burst(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      tx_data  = base + 8'(i);
      tx_valid = 1'b1;
      @(negedge clk);
    end
    tx_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (tx_busy !== 1'b0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    repeat (5) @(negedge clk);
    check(name, tx_busy, 1'b0);
  endtask

  initial begin
    #950_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] t1_frame;
    int         base;
    int         t;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_txd",  uart_txd,    1'b1);
    check("rst_busy", tx_busy,     1'b0);
    check("rst_full", tx_full,     1'b0);
    check("rst_ovf",  tx_overflow, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single byte 0x55, line pinned by hand
    t1_frame = 10'b1010101010;
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("t1_txd_n",  uart_txd, 1'b1);
    @(negedge clk);
    check("t1_txd_n1", uart_txd, 1'b1);
    @(negedge clk);
    check("t1_txd_n2", uart_txd, 1'b0);
    repeat (5) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      check("t1_bit", uart_txd, t1_frame[i]);
      if (i < 9) repeat (CPB) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    check("t1_busy_last", tx_busy, 1'b1);
    @(negedge clk);
    check("t1_busy_fall", tx_busy, 1'b0);
    check("t1_idle_line", uart_txd, 1'b1);
    drain("t1_drain");

    // 2: burst of five, back to back
    base = frames_decoded;
    burst(5, 8'h31);
    check("t2_full",  tx_full,     1'b1);
    check("t2_ovf",   tx_overflow, 1'b0);
    drain("t2_drain");
    check("t2_frames", frames_decoded - base, 5);

    // 3: overflow on the sixth write
    do_reset();
    base = frames_decoded;
    burst(6, 8'hA0);
    check("t3_ovf",  tx_overflow, 1'b1);
    check("t3_full", tx_full,     1'b1);
    drain("t3_drain");
    check("t3_ovf_sticky", tx_overflow, 1'b1);
    check("t3_frames", frames_decoded - base, 5);

    // 4: write while full on the STOP->START pop edge
    do_reset();
    base = frames_decoded;
    burst(5, 8'hB0);
    repeat (96) @(negedge clk);
    check("t4_full_pre", tx_full,     1'b1);
    check("t4_ovf_pre",  tx_overflow, 1'b0);
    tx_data  = 8'hEE;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("t4_ovf",  tx_overflow, 1'b1);
    check("t4_full", tx_full,     1'b0);
    drain("t4_drain");
    check("t4_frames", frames_decoded - base, 5);

    // 5: asynchronous reset in data bit 3
    do_reset();
    tx_data  = 8'h33;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (45) @(negedge clk);
    check("t5_txd_pre", uart_txd, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("t5_txd_async",  uart_txd, 1'b1);
    check("t5_busy_async", tx_busy,  1'b0);
    repeat (2) @(negedge clk);
    rst  = 1'b1;
    base = frames_decoded;
    @(negedge clk);
    tx_data  = 8'h0F;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    drain("t5_drain");
    check("t5_frames", frames_decoded - base, 1);

    // 6: random scoreboard, FIFO never allowed to fill
    do_reset();
    base = frames_decoded;
    for (int n = 0; n < 200; n++) begin
      repeat ($urandom_range(0, 150)) @(negedge clk);
      t = 0;
      while (m_q.size() >= DEPTH - 1 && t < 2000) begin
        @(negedge clk);
        t++;
      end
      tx_data  = 8'($urandom);
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
    end
    drain("t6_drain");
    check("t6_frames",   frames_decoded - base, 200);
    check("t6_ovf",      tx_overflow, 1'b0);
    check("t6_exp_left", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_uart_tx

`default_nettype wire
